// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, RGB332 colour layout and window helper.
// Imported by the timing generator and the layer compositor.
package vga_pkg;
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int RED_W   = 3;
   localparam int GREEN_W = 3;
   localparam int BLUE_W  = 2;
   localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

   localparam logic [RGB_W-1:0] BG_COLOR_DEFAULT = 8'b000_000_01;

   typedef struct packed {
      logic [RED_W-1:0]   red;
      logic [GREEN_W-1:0] green;
      logic [BLUE_W-1:0]  blue;
   } rgb332_t;

   // True when pos lies in [first, first+len).
   function automatic logic in_window(input logic [9:0] pos, input int first, input int len);
      return (pos >= 10'(first)) && (pos < 10'(first + len));
   endfunction
endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider and h/v scan counters with visible/sync decode and frame-wrap strobe.
// Counters advance on the clock edge where tick is high; all decodes are combinational.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int H_VIS   = H_VISIBLE,
   parameter int H_FP    = H_FRONT,
   parameter int H_SW    = H_SYNC,
   parameter int H_BP    = H_BACK,
   parameter int V_VIS   = V_VISIBLE,
   parameter int V_FP    = V_FRONT,
   parameter int V_SW    = V_SYNC,
   parameter int V_BP    = V_BACK
) (
   input  logic       clock,
   input  logic       reset,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       tick,
   output logic       visible,
   output logic       hsync_on,
   output logic       vsync_on,
   output logic       frame_wrap
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SW + V_BP - 1);

   logic [DW-1:0] div;
   logic          h_last;
   logic          v_last;

   assign tick   = (div == DW'(CLK_DIV - 1));
   assign h_last = (hcount == H_LAST);
   assign v_last = (vcount == V_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         div    <= '0;
         hcount <= '0;
         vcount <= '0;
      end else if (tick) begin
         div <= '0;
         if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? 10'd0 : vcount + 10'd1;
         end else begin
            hcount <= hcount + 10'd1;
         end
      end else begin
         div <= div + 1'b1;
      end
   end

   assign visible    = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
   assign hsync_on   = in_window(hcount, H_VIS + H_FP, H_SW);
   assign vsync_on   = in_window(vcount, V_VIS + V_FP, V_SW);
   assign frame_wrap = tick && h_last && v_last;
endmodule

// File: rtl/vga_compositor.sv
// VGA timing master and fixed-priority layer mixer with per-frame player collision report.
// Pins lag hcount/vcount by one pixel period; layer inputs are sampled only on the pixel tick.
module vga_compositor
   import vga_pkg::*;
#(
   parameter int               CLK_DIV    = 2,
   parameter int               NUM_LAYERS = 4,
   parameter logic [RGB_W-1:0] BG_COLOR   = BG_COLOR_DEFAULT,
   parameter int               H_VIS      = H_VISIBLE,
   parameter int               H_FP       = H_FRONT,
   parameter int               H_SW       = H_SYNC,
   parameter int               H_BP       = H_BACK,
   parameter int               V_VIS      = V_VISIBLE,
   parameter int               V_FP       = V_FRONT,
   parameter int               V_SW       = V_SYNC,
   parameter int               V_BP       = V_BACK
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb,
   input  logic [NUM_LAYERS-1:0]       layer_data,
   output logic [9:0]                  hcount,
   output logic [9:0]                  vcount,
   output logic                        hsync,
   output logic                        vsync,
   output logic [RED_W-1:0]            red,
   output logic [GREEN_W-1:0]          green,
   output logic [BLUE_W-1:0]           blue,
   output logic                        frame_tick,
   output logic [NUM_LAYERS-1:0]       collision
);
   logic                  tick;
   logic                  visible;
   logic                  hsync_on;
   logic                  vsync_on;
   logic                  frame_wrap;
   rgb332_t               mix;
   rgb332_t               pix_q;
   logic [NUM_LAYERS-1:0] hit;
   logic [NUM_LAYERS-1:0] acc;

   vga_timing #(
      .CLK_DIV (CLK_DIV),
      .H_VIS   (H_VIS),
      .H_FP    (H_FP),
      .H_SW    (H_SW),
      .H_BP    (H_BP),
      .V_VIS   (V_VIS),
      .V_FP    (V_FP),
      .V_SW    (V_SW),
      .V_BP    (V_BP)
   ) u_timing (
      .clock      (clock),
      .reset      (reset),
      .hcount     (hcount),
      .vcount     (vcount),
      .tick       (tick),
      .visible    (visible),
      .hsync_on   (hsync_on),
      .vsync_on   (vsync_on),
      .frame_wrap (frame_wrap)
   );

   // Walk from lowest priority upwards so layer 0 overrides everything.
   always_comb begin
      mix = BG_COLOR;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_data[i]) mix = layer_rgb[RGB_W*i +: RGB_W];
      end
      if (!visible) mix = '0;
   end

   always_comb begin
      hit = '0;
      for (int i = 1; i < NUM_LAYERS; i++) begin
         hit[i] = layer_data[0] & layer_data[i];
      end
      if (!visible) hit = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         pix_q      <= '0;
         frame_tick <= 1'b0;
         collision  <= '0;
         acc        <= '0;
      end else begin
         frame_tick <= 1'b0;
         if (tick) begin
            hsync <= ~hsync_on;
            vsync <= ~vsync_on;
            pix_q <= mix;
            acc   <= acc | hit;
            // The last pixel's own term is folded in before the accumulator clears.
            if (frame_wrap) begin
               collision  <= acc | hit;
               acc        <= '0;
               frame_tick <= 1'b1;
            end
         end
      end
   end

   assign red   = pix_q.red;
   assign green = pix_q.green;
   assign blue  = pix_q.blue;
endmodule

// File: tb/tb_vga_compositor.sv
// Randomized bench for vga_compositor on a shrunken raster, checked against a pixel-index model.
module tb_vga_compositor;
   localparam int CD = 2;
   localparam int NL = 4;
   localparam int HV = 16, HF = 2, HS = 4, HB = 3;
   localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME_CLKS = HT * VT * CD;
   localparam logic [7:0] BG = 8'h01;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [8*NL-1:0] layer_rgb = '0;
   logic [NL-1:0]   layer_data = '0;
   logic [9:0]      hcount;
   logic [9:0]      vcount;
   logic            hsync;
   logic            vsync;
   logic [2:0]      red;
   logic [2:0]      green;
   logic [1:0]      blue;
   logic            frame_tick;
   logic [NL-1:0]   collision;

   vga_compositor #(
      .CLK_DIV (CD), .NUM_LAYERS (NL), .BG_COLOR (BG),
      .H_VIS (HV), .H_FP (HF), .H_SW (HS), .H_BP (HB),
      .V_VIS (VV), .V_FP (VF), .V_SW (VS), .V_BP (VB)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .layer_rgb  (layer_rgb),
      .layer_data (layer_data),
      .hcount     (hcount),
      .vcount     (vcount),
      .hsync      (hsync),
      .vsync      (vsync),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .frame_tick (frame_tick),
      .collision  (collision)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   // Model: k = clock edges since reset; pixel index = k / CD.
   int            k = 0;
   logic [NL-1:0] m_acc = '0;
   logic [NL-1:0] m_coll = '0;
   logic          m_hs = 1'b1;
   logic          m_vs = 1'b1;
   logic          m_ft = 1'b0;
   logic [7:0]    m_rgb = '0;

   function automatic int cur_h();
      return (k / CD) % HT;
   endfunction

   function automatic int cur_v();
      return (k / CD / HT) % VT;
   endfunction

   function automatic logic [34:0] model_vec();
      return {10'(cur_h()), 10'(cur_v()), m_hs, m_vs, m_rgb, m_ft, m_coll};
   endfunction

   function automatic logic [34:0] dut_vec();
      return {hcount, vcount, hsync, vsync, red, green, blue, frame_tick, collision};
   endfunction

   function automatic logic [8*NL-1:0] rand_rgb();
      logic [8*NL-1:0] r;
      for (int i = 0; i < NL; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   function automatic logic [NL-1:0] rand_dat();
      logic [NL-1:0] d;
      for (int i = 0; i < NL; i++) d[i] = ($urandom_range(0, 2) == 0);
      return d;
   endfunction

   task automatic step(input logic rst, input logic [8*NL-1:0] rgb, input logic [NL-1:0] dat);
      int  h;
      int  v;
      bit  found;
      reset      = rst;
      layer_rgb  = rgb;
      layer_data = dat;
      @(posedge clock);
      if (rst) begin
         k = 0; m_acc = '0; m_coll = '0; m_hs = 1'b1; m_vs = 1'b1; m_rgb = '0; m_ft = 1'b0;
      end else begin
         m_ft = 1'b0;
         if (k % CD == CD - 1) begin
            h = cur_h();
            v = cur_v();
            m_hs = !(h >= HV + HF && h < HV + HF + HS);
            m_vs = !(v >= VV + VF && v < VV + VF + VS);
            m_rgb = '0;
            if (h < HV && v < VV) begin
               m_rgb = BG;
               found = 0;
               for (int i = 0; i < NL; i++) begin
                  if (dat[i] && !found) begin
                     m_rgb = rgb[8*i +: 8];
                     found = 1;
                  end
               end
               for (int i = 1; i < NL; i++) if (dat[0] && dat[i]) m_acc[i] = 1'b1;
            end
            if (h == HT - 1 && v == VT - 1) begin
               m_coll = m_acc;
               m_acc  = '0;
               m_ft   = 1'b1;
            end
         end
         k++;
      end
      #1;
   endtask

   task automatic goto(input int h, input int v);
      int n = 0;
      while (!(cur_h() == h && cur_v() == v && k % CD == 0) && n < 2 * FRAME_CLKS) begin
         step(1'b0, rand_rgb(), rand_dat());
         n++;
      end
      if (n >= 2 * FRAME_CLKS) begin
         miscompares++;
         $display("FAIL goto_timeout: did not reach (%0d,%0d), at (%0d,%0d)", h, v, cur_h(), cur_v());
      end
   endtask

   task automatic test_reset;
      step(1'b1, '0, '0);
      step(1'b1, rand_rgb(), rand_dat());
      vectors++;
      if (dut_vec() !== model_vec()) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_random(input int frames);
      for (int s = 0; s < frames * FRAME_CLKS; s++) begin
         step(1'b0, rand_rgb(), rand_dat());
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL random k=%0d: got %h want %h", k, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_reset_mid;
      goto(10, 3);
      step(1'b1, rand_rgb(), 4'hF);
      vectors++;
      if ({hcount, vcount, hsync, vsync, red, green, blue, collision, frame_tick} !== {20'd0, 2'b11, 8'd0, 4'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid: got h=%0d v=%0d hs=%b vs=%b rgb=%h coll=%b ft=%b want zeros/syncs high",
                  hcount, vcount, hsync, vsync, {red, green, blue}, collision, frame_tick);
      end
      step(1'b0, rand_rgb(), rand_dat());
      vectors++;
      if (hcount !== 10'd0) begin
         miscompares++;
         $display("FAIL first_tick_early: got hcount=%0d want 0", hcount);
      end
      step(1'b0, rand_rgb(), rand_dat());
      vectors++;
      if (hcount !== 10'd1) begin
         miscompares++;
         $display("FAIL first_tick: got hcount=%0d want 1", hcount);
      end
   endtask

   task automatic test_priority;
      logic [8*NL-1:0] rgb;
      logic [NL-1:0]   pats [3];
      logic [7:0]      want [3];
      pats[0] = 4'b0011; pats[1] = 4'b0010; pats[2] = 4'b0000;
      want[0] = 8'hE0;   want[1] = 8'h1C;   want[2] = 8'h01;
      goto(5, 2);
      for (int p = 0; p < 3; p++) begin
         rgb = rand_rgb();
         rgb[7:0]  = 8'hE0;
         rgb[15:8] = 8'h1C;
         for (int c = 0; c < CD; c++) begin
            step(1'b0, rgb, pats[p]);
            vectors++;
            if (dut_vec() !== model_vec()) begin
               miscompares++;
               $display("FAIL priority_model: got %h want %h", dut_vec(), model_vec());
            end
         end
         vectors++;
         if ({red, green, blue} !== want[p]) begin
            miscompares++;
            $display("FAIL priority data=%b: got %h want %h", pats[p], {red, green, blue}, want[p]);
         end
      end
   endtask

   task automatic test_blanking;
      int ph;
      int pv;
      goto(0, 0);
      for (int s = 0; s < FRAME_CLKS; s++) begin
         step(1'b0, rand_rgb(), (cur_h() < HV && cur_v() < VV) ? 4'h0 : 4'hF);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL blanking_model: got %h want %h", dut_vec(), model_vec());
         end
         if (k % CD == 0) begin
            ph = (k / CD - 1) % HT;
            pv = ((k / CD - 1) / HT) % VT;
            if ((ph >= HV || pv >= VV) && {red, green, blue} !== 8'h00) begin
               miscompares++;
               $display("FAIL blank_rgb (%0d,%0d): got %h want 00", ph, pv, {red, green, blue});
            end
         end
      end
      vectors++;
      if ({frame_tick, collision} !== 5'b1_0000) begin
         miscompares++;
         $display("FAIL blank_collision: got ft=%b coll=%b want 1 0000", frame_tick, collision);
      end
   endtask

   task automatic test_collision;
      logic [NL-1:0] d;
      logic [NL-1:0] want [3];
      want[0] = 4'b0100; want[1] = 4'b0000; want[2] = 4'b1000;
      goto(0, 0);
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < FRAME_CLKS; s++) begin
            d = rand_dat();
            if (d[0]) d = 4'b0001;
            if (f == 0 && cur_h() == 7 && cur_v() == 3) d = 4'b0101;
            if (f == 2 && cur_h() == HV - 1 && cur_v() == VV - 1) d = 4'b1001;
            step(1'b0, rand_rgb(), d);
            vectors++;
            if (dut_vec() !== model_vec()) begin
               miscompares++;
               $display("FAIL collision_model f=%0d: got %h want %h", f, dut_vec(), model_vec());
            end
         end
         vectors++;
         if ({frame_tick, collision} !== {1'b1, want[f]}) begin
            miscompares++;
            $display("FAIL collision f=%0d: got ft=%b coll=%b want 1 %b", f, frame_tick, collision, want[f]);
         end
      end
   endtask

   task automatic test_sync_timing;
      int hs_low = 0;
      int vs_low = 0;
      int first_low = -1;
      int ft_at [$];
      goto(0, 0);
      for (int s = 0; s < 2 * FRAME_CLKS; s++) begin
         step(1'b0, rand_rgb(), rand_dat());
         if (s < HT * CD && !hsync) begin
            hs_low++;
            if (first_low < 0) first_low = s;
         end
         if (s < FRAME_CLKS && !vsync) vs_low++;
         if (frame_tick) ft_at.push_back(s);
      end
      vectors++;
      if (hs_low !== HS * CD) begin
         miscompares++;
         $display("FAIL hsync_width: got %0d clocks want %0d", hs_low, HS * CD);
      end
      // Sync goes low on the tick that leaves pixel HV+HF, i.e. CD clocks after hcount reaches it.
      vectors++;
      if (first_low !== (HV + HF + 1) * CD - 1) begin
         miscompares++;
         $display("FAIL hsync_start: got step %0d want %0d", first_low, (HV + HF + 1) * CD - 1);
      end
      vectors++;
      if (vs_low !== VS * HT * CD) begin
         miscompares++;
         $display("FAIL vsync_width: got %0d clocks want %0d", vs_low, VS * HT * CD);
      end
      vectors++;
      if (ft_at.size() != 2 || ft_at[1] - ft_at[0] != FRAME_CLKS) begin
         miscompares++;
         $display("FAIL frame_period: got %0d pulses, spacing %0d want 2, %0d", ft_at.size(),
                  (ft_at.size() >= 2) ? ft_at[1] - ft_at[0] : -1, FRAME_CLKS);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_random(3);
      test_reset_mid();
      test_random(2);
      test_priority();
      test_blanking();
      test_collision();
      test_sync_timing();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
